// File: rtl/bldc_pkg.sv
// Shared types, constants and decode helpers for the six-step BLDC commutator.
// Pattern words are {hi[2:0], lo[2:0]} with leg order {C,B,A}.
package bldc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEAD,
        ST_RUN,
        ST_FAULT
    } state_e;

    localparam logic [2:0] SECTOR_NONE = 3'd7;

    // Forward drive per sector: s0 A+B-, s1 A+C-, s2 B+C-, s3 B+A-, s4 C+A-, s5 C+B-
    localparam logic [5:0] FWD_TABLE [6] = '{
        6'b001_010,
        6'b001_100,
        6'b010_100,
        6'b010_001,
        6'b100_001,
        6'b100_010
    };

    function automatic logic [2:0] hall_to_sector(input logic [2:0] code);
        case (code)
            3'b001:  return 3'd0;
            3'b101:  return 3'd1;
            3'b100:  return 3'd2;
            3'b110:  return 3'd3;
            3'b010:  return 3'd4;
            3'b011:  return 3'd5;
            default: return SECTOR_NONE;
        endcase
    endfunction

    // Reverse rotation drives the same legs with high and low sides swapped.
    function automatic logic [5:0] sector_pattern(input logic [2:0] sector, input logic rev);
        logic [5:0] fwd;
        fwd = (sector < 3'd6) ? FWD_TABLE[sector] : 6'b000_000;
        return rev ? {fwd[2:0], fwd[5:3]} : fwd;
    endfunction

endpackage

// File: rtl/bldc_hall_filter.sv
// Hall input 2-flop synchroniser plus debounce; code_o follows after DEBOUNCE stable samples.
// Latency 2 + DEBOUNCE cycles from a Hall edge to code_o; no backpressure.
module bldc_hall_filter
    import bldc_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] hall_i,
    output logic [2:0] code_o
);

    localparam logic [8:0] DB_LEN = 9'(DEBOUNCE);

    logic [2:0] sync1_q, sync2_q, cand_q, code_q;
    logic [7:0] cnt_q;
    logic [8:0] run_len;

    // run_len counts consecutive identical synchronised samples including this one
    assign run_len = (sync2_q == cand_q) ? ({1'b0, cnt_q} + 9'd1) : 9'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            cand_q  <= 3'b000;
            cnt_q   <= 8'd0;
            code_q  <= 3'b000;
        end else begin
            sync1_q <= hall_i;
            sync2_q <= sync1_q;
            cand_q  <= sync2_q;
            cnt_q   <= (run_len >= DB_LEN) ? DB_LEN[7:0] : run_len[7:0];
            if (run_len >= DB_LEN) begin
                code_q <= sync2_q;
            end
        end
    end

    assign code_o = code_q;

endmodule

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutator: Hall filter, sector FSM with dead time, PWM-chopped high side, fault latch.
// Gates change the cycle after the filtered code; optional BLDC_SPEED_EN adds the commutation period counter.
module bldc_commutator
    import bldc_pkg::*;
#(
    parameter int DEBOUNCE = 4,
    parameter int DEADTIME = 8,
    parameter int PWM_W    = 8,
    parameter int PER_W    = 20
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             dir_i,
    input  logic [2:0]       hall_i,
    input  logic [PWM_W-1:0] duty_i,
    input  logic             fault_clr_i,
    output logic [2:0]       hi_o,
    output logic [2:0]       lo_o,
    output logic [2:0]       sector_o,
    output logic             comm_o,
    output logic             fault_o,
    output logic [PER_W-1:0] period_o
);

    localparam logic [7:0] DEAD_LEN = 8'(DEADTIME);

    logic [2:0]       filt_code, filt_sector;
    logic             filt_valid, retarget, pwm_on;
    logic [5:0]       tgt_pat, dead_hold, dead_run, dead_retgt;
    logic [2:0]       pwm_mask;
    state_e           state_q;
    logic [5:0]       old_pat_q, new_pat_q;
    logic [2:0]       code_q;
    logic             dir_q;
    logic [7:0]       dead_cnt_q;
    logic [PWM_W-1:0] pwm_cnt_q;
    logic [2:0]       hi_q, lo_q, sector_q;
    logic             comm_q, fault_q;

    bldc_hall_filter #(
        .DEBOUNCE(DEBOUNCE)
    ) u_hall_filter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .hall_i (hall_i),
        .code_o (filt_code)
    );

    assign filt_sector = hall_to_sector(filt_code);
    assign filt_valid  = (filt_sector != SECTOR_NONE);
    assign tgt_pat     = sector_pattern(filt_sector, dir_i);
    assign retarget    = (filt_code != code_q) || (dir_i != dir_q);
    assign pwm_on      = (pwm_cnt_q < duty_i);
    assign pwm_mask    = {3{pwm_on}};

    // Dead-time drive keeps only switches common to both patterns, so turn-offs happen at once
    assign dead_hold  = old_pat_q & new_pat_q;
    assign dead_run   = new_pat_q & tgt_pat;
    assign dead_retgt = old_pat_q & tgt_pat;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            old_pat_q  <= 6'b0;
            new_pat_q  <= 6'b0;
            code_q     <= 3'b000;
            dir_q      <= 1'b0;
            dead_cnt_q <= 8'd0;
            hi_q       <= 3'b000;
            lo_q       <= 3'b000;
            sector_q   <= SECTOR_NONE;
            comm_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else if (!enable_i && state_q != ST_FAULT) begin
            state_q  <= ST_IDLE;
            hi_q     <= 3'b000;
            lo_q     <= 3'b000;
            sector_q <= SECTOR_NONE;
            comm_q   <= 1'b0;
        end else if (!filt_valid && state_q != ST_FAULT) begin
            state_q  <= ST_FAULT;
            hi_q     <= 3'b000;
            lo_q     <= 3'b000;
            sector_q <= SECTOR_NONE;
            comm_q   <= 1'b0;
            fault_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q    <= ST_DEAD;
                    old_pat_q  <= 6'b0;
                    new_pat_q  <= tgt_pat;
                    code_q     <= filt_code;
                    dir_q      <= dir_i;
                    dead_cnt_q <= 8'd1;
                    hi_q       <= 3'b000;
                    lo_q       <= 3'b000;
                    sector_q   <= filt_sector;
                    comm_q     <= 1'b1;
                end
                ST_DEAD: begin
                    if (retarget) begin
                        // Restart dead time toward the newest pattern; old_pat_q is what last drove
                        new_pat_q  <= tgt_pat;
                        code_q     <= filt_code;
                        dir_q      <= dir_i;
                        dead_cnt_q <= 8'd1;
                        hi_q       <= dead_retgt[5:3] & pwm_mask;
                        lo_q       <= dead_retgt[2:0];
                        sector_q   <= filt_sector;
                        comm_q     <= (filt_code != code_q);
                    end else if (dead_cnt_q >= DEAD_LEN) begin
                        state_q <= ST_RUN;
                        hi_q    <= new_pat_q[5:3] & pwm_mask;
                        lo_q    <= new_pat_q[2:0];
                        comm_q  <= 1'b0;
                    end else begin
                        dead_cnt_q <= dead_cnt_q + 8'd1;
                        hi_q       <= dead_hold[5:3] & pwm_mask;
                        lo_q       <= dead_hold[2:0];
                        comm_q     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (retarget) begin
                        state_q    <= ST_DEAD;
                        old_pat_q  <= new_pat_q;
                        new_pat_q  <= tgt_pat;
                        code_q     <= filt_code;
                        dir_q      <= dir_i;
                        dead_cnt_q <= 8'd1;
                        hi_q       <= dead_run[5:3] & pwm_mask;
                        lo_q       <= dead_run[2:0];
                        sector_q   <= filt_sector;
                        comm_q     <= (filt_code != code_q);
                    end else begin
                        hi_q   <= new_pat_q[5:3] & pwm_mask;
                        lo_q   <= new_pat_q[2:0];
                        comm_q <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    hi_q     <= 3'b000;
                    lo_q     <= 3'b000;
                    sector_q <= SECTOR_NONE;
                    comm_q   <= 1'b0;
                    fault_q  <= 1'b1;
                    if (fault_clr_i && filt_valid) begin
                        state_q <= ST_IDLE;
                        fault_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BLDC_SPEED_EN
    logic [PER_W-1:0] per_cnt_q, period_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            per_cnt_q <= '0;
            period_q  <= '0;
        end else if (state_q == ST_IDLE || state_q == ST_FAULT) begin
            per_cnt_q <= '0;
        end else if (comm_q) begin
            period_q  <= per_cnt_q;
            per_cnt_q <= PER_W'(1);
        end else if (per_cnt_q != '1) begin
            per_cnt_q <= per_cnt_q + 1'b1;
        end
    end

    assign period_o = period_q;
`else
    assign period_o = '0;
`endif

    assign hi_o     = hi_q;
    assign lo_o     = lo_q;
    assign sector_o = sector_q;
    assign comm_o   = comm_q;
    assign fault_o  = fault_q;

endmodule

// File: tb/tb_bldc_commutator.sv
// Scoreboard bench for bldc_commutator: expected transitions are queued when Hall stimulus is driven
// and checked when the commutation pulse appears.
module tb_bldc_commutator;

    localparam int PWM_W = 8;
    localparam int PER_W = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, enable, dir, fault_clr;
    logic [2:0]       hall;
    logic [PWM_W-1:0] duty;
    logic [2:0]       hi_o, lo_o, sector_o;
    logic             comm_o, fault_o;
    logic [PER_W-1:0] period_o;

    typedef struct {
        int         sector;
        logic [2:0] ohi, olo, nhi, nlo;
    } exp_t;

    exp_t       sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [2:0] cur_hi, cur_lo;
    logic       cur_dir;
    int         cur_sector;
    logic [2:0] hall_of [6];
    int         hi_leg [6];
    int         lo_leg [6];

    bldc_commutator #(
        .DEBOUNCE(4), .DEADTIME(8), .PWM_W(PWM_W), .PER_W(PER_W)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .dir_i(dir), .hall_i(hall),
        .duty_i(duty), .fault_clr_i(fault_clr), .hi_o(hi_o), .lo_o(lo_o),
        .sector_o(sector_o), .comm_o(comm_o), .fault_o(fault_o), .period_o(period_o)
    );

    function automatic logic [5:0] model_pat(int s, logic d);
        logic [2:0] h, l;
        h = 3'(1 << hi_leg[s]);
        l = 3'(1 << lo_leg[s]);
        return d ? {l, h} : {h, l};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int s);
        exp_t       e;
        logic [5:0] np;
        np = model_pat(s, cur_dir);
        e.sector = s;
        e.ohi = cur_hi; e.olo = cur_lo; e.nhi = np[5:3]; e.nlo = np[2:0];
        sb.push_back(e);
        cur_hi = np[5:3]; cur_lo = np[2:0]; cur_sector = s;
    endtask

    task automatic expect_comm(input int maxw, output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!comm_o && waited < maxw);
        n_vec++;
        if (comm_o !== 1'b1) begin
            n_err++;
            $display("FAIL comm_timeout: no comm within %0d cycles (comm=%b, want 1)", maxw, comm_o);
        end
    endtask

    task automatic hold(input int n, input string tag);
        int c = 0;
        repeat (n) begin
            tick();
            if (comm_o) c++;
        end
        n_vec++;
        if (c != 0) begin
            n_err++;
            $display("FAIL %s_extra_comm: got %0d comm pulses, want 0", tag, c);
        end
    endtask

    task automatic check_transition(input string tag);
        exp_t       e;
        logic [2:0] orh, hi1, hi2;
        int         bad_lo = 0, bad_hi = 0, shoot = 0, wide = 0;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s_sb_empty: got 0 queued entries, want 1", tag);
            return;
        end
        e = sb.pop_front();
        n_vec++;
        if (sector_o !== 3'(e.sector)) begin
            n_err++;
            $display("FAIL %s_sector: got %0d want %0d", tag, sector_o, e.sector);
        end
        orh = 3'b000;
        for (int d = 0; d < 8; d++) begin
            if (lo_o !== (e.olo & e.nlo)) bad_lo++;
            if ((hi_o & ~(e.ohi & e.nhi)) != 3'b000) bad_hi++;
            if ((hi_o & lo_o) != 3'b000) shoot++;
            if (d > 0 && comm_o) wide++;
            orh = orh | hi_o;
            tick();
        end
        n_vec++;
        if (bad_lo != 0) begin
            n_err++;
            $display("FAIL %s_dead_lo: %0d bad cycles, want lo=%b", tag, bad_lo, e.olo & e.nlo);
        end
        n_vec++;
        if (bad_hi != 0) begin
            n_err++;
            $display("FAIL %s_dead_hi: %0d cycles with hi outside %b", tag, bad_hi, e.ohi & e.nhi);
        end
        n_vec++;
        if (orh !== (e.ohi & e.nhi)) begin
            n_err++;
            $display("FAIL %s_dead_hold: got hi %b want %b", tag, orh, e.ohi & e.nhi);
        end
        n_vec++;
        if (shoot != 0 || wide != 0) begin
            n_err++;
            $display("FAIL %s_dead_safety: shoot=%0d comm_extra=%0d want 0/0", tag, shoot, wide);
        end
        n_vec++;
        if (lo_o !== e.nlo) begin
            n_err++;
            $display("FAIL %s_run_lo: got %b want %b", tag, lo_o, e.nlo);
        end
        hi1 = hi_o;
        tick();
        hi2 = hi_o;
        n_vec++;
        if ((hi1 | hi2) !== e.nhi) begin
            n_err++;
            $display("FAIL %s_run_hi: got %b want %b", tag, hi1 | hi2, e.nhi);
        end
    endtask

    task automatic step(input int s, input int hold_n, input string tag);
        int w;
        hall = hall_of[s];
        push_exp(s);
        expect_comm(20, w);
        n_vec++;
        if (w != 7) begin
            n_err++;
            $display("FAIL %s_latency: got %0d cycles want 7", tag, w);
        end
        check_transition(tag);
        hold(hold_n, tag);
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; dir = 1'b0; hall = 3'b001; duty = 8'd255; fault_clr = 1'b0;
        repeat (3) tick();
        n_vec++; if (hi_o !== 3'b000) begin n_err++; $display("FAIL rst_hi: got %b want 000", hi_o); end
        n_vec++; if (lo_o !== 3'b000) begin n_err++; $display("FAIL rst_lo: got %b want 000", lo_o); end
        n_vec++; if (sector_o !== 3'd7) begin n_err++; $display("FAIL rst_sector: got %0d want 7", sector_o); end
        n_vec++; if (comm_o !== 1'b0) begin n_err++; $display("FAIL rst_comm: got %b want 0", comm_o); end
        n_vec++; if (fault_o !== 1'b0) begin n_err++; $display("FAIL rst_fault: got %b want 0", fault_o); end
        n_vec++; if (period_o !== '0) begin n_err++; $display("FAIL rst_period: got %0d want 0", period_o); end
        rst = 1'b0;
    endtask

    task automatic test_start();
        int w;
        repeat (10) tick();
        n_vec++;
        if (sector_o !== 3'd7 || comm_o !== 1'b0) begin
            n_err++;
            $display("FAIL idle_disabled: got sector %0d comm %b want 7/0", sector_o, comm_o);
        end
        cur_hi = 3'b000; cur_lo = 3'b000; cur_dir = 1'b0;
        push_exp(0);
        enable = 1'b1;
        expect_comm(20, w);
        n_vec++;
        if (w != 1) begin n_err++; $display("FAIL enable_latency: got %0d want 1", w); end
        check_transition("start");
        hold(80, "start");
    endtask

    task automatic test_rotation(input logic d, input string tag);
        for (int i = 1; i <= 6; i++) step(i % 6, 100, tag);
    endtask

    task automatic test_dir_toggle();
        logic [5:0] np;
        logic [2:0] ohi, olo;
        int c = 0, bad = 0, shoot = 0;
        ohi = cur_hi; olo = cur_lo;
        np = model_pat(cur_sector, 1'b1);
        dir = 1'b1; cur_dir = 1'b1;
        for (int d = 1; d <= 8; d++) begin
            tick();
            if (comm_o) c++;
            if ((hi_o & ~(ohi & np[5:3])) != 3'b000) bad++;
            if (lo_o !== (olo & np[2:0])) bad++;
            if ((hi_o & lo_o) != 3'b000) shoot++;
        end
        tick();
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL dir_dead: %0d bad samples want 0", bad); end
        n_vec++; if (shoot != 0) begin n_err++; $display("FAIL dir_shoot: %0d samples want 0", shoot); end
        n_vec++; if (c != 0) begin n_err++; $display("FAIL dir_comm: got %0d pulses want 0", c); end
        n_vec++; if (lo_o !== np[2:0]) begin n_err++; $display("FAIL dir_run_lo: got %b want %b", lo_o, np[2:0]); end
        n_vec++; if (sector_o !== 3'(cur_sector)) begin n_err++; $display("FAIL dir_sector: got %0d want %0d", sector_o, cur_sector); end
        cur_hi = np[5:3]; cur_lo = np[2:0];
        hold(40, "dir");
    endtask

    task automatic test_glitch();
        hall = 3'b011;
        repeat (3) tick();
        hall = 3'b001;
        hold(30, "glitch");
        n_vec++;
        if (sector_o !== 3'd0) begin n_err++; $display("FAIL glitch_sector: got %0d want 0", sector_o); end
        step(5, 60, "accept");
    endtask

    task automatic test_fault();
        int w = 0;
        hall = 3'b111;
        do begin tick(); w++; end while (!fault_o && w < 20);
        n_vec++; if (fault_o !== 1'b1) begin n_err++; $display("FAIL fault_set: got %b want 1", fault_o); end
        n_vec++; if (w != 7) begin n_err++; $display("FAIL fault_latency: got %0d want 7", w); end
        n_vec++;
        if (hi_o !== 3'b000 || lo_o !== 3'b000 || sector_o !== 3'd7) begin
            n_err++;
            $display("FAIL fault_outputs: got hi %b lo %b sector %0d want 000/000/7", hi_o, lo_o, sector_o);
        end
        fault_clr = 1'b1; tick(); fault_clr = 1'b0;
        repeat (3) tick();
        n_vec++; if (fault_o !== 1'b1) begin n_err++; $display("FAIL fault_clr_invalid: got %b want 1", fault_o); end
        hall = 3'b001;
        repeat (10) tick();
        n_vec++; if (fault_o !== 1'b1) begin n_err++; $display("FAIL fault_latched: got %b want 1", fault_o); end
        fault_clr = 1'b1; tick(); fault_clr = 1'b0;
        n_vec++;
        if (fault_o !== 1'b0 || sector_o !== 3'd7 || (hi_o | lo_o) !== 3'b000) begin
            n_err++;
            $display("FAIL fault_exit: got fault %b sector %0d gates %b want 0/7/000", fault_o, sector_o, hi_o | lo_o);
        end
        cur_hi = 3'b000; cur_lo = 3'b000;
        push_exp(0);
        expect_comm(20, w);
        n_vec++; if (w != 1) begin n_err++; $display("FAIL recover_latency: got %0d want 1", w); end
        check_transition("recover");
        hold(50, "recover");
    endtask

    task automatic test_pwm_duty(input logic [PWM_W-1:0] dv, input int want_on, input string tag);
        int on = 0, badlo = 0, extra = 0;
        duty = dv;
        repeat (2) tick();
        repeat (256) begin
            if (hi_o != 3'b000) on++;
            if (lo_o !== cur_lo) badlo++;
            if ((hi_o & ~cur_hi) != 3'b000) extra++;
            tick();
        end
        n_vec++; if (on != want_on) begin n_err++; $display("FAIL %s_on: got %0d cycles want %0d", tag, on, want_on); end
        n_vec++; if (badlo != 0 || extra != 0) begin n_err++; $display("FAIL %s_gates: lo bad %0d hi extra %0d want 0/0", tag, badlo, extra); end
    endtask

    task automatic test_pwm();
        test_pwm_duty(8'd64, 64, "pwm64");
        test_pwm_duty(8'd0, 0, "pwm0");
        duty = 8'd255;
        repeat (2) tick();
    endtask

    task automatic test_speed();
`ifdef BLDC_SPEED_EN
        hall = hall_of[(cur_sector + 1) % 6];
        repeat (1000) tick();
        hall = hall_of[(cur_sector + 2) % 6];
        repeat (20) tick();
        n_vec++;
        if (period_o !== PER_W'(1000)) begin n_err++; $display("FAIL period: got %0d want 1000", period_o); end
        cur_sector = (cur_sector + 2) % 6;
`else
        repeat (20) tick();
        n_vec++;
        if (period_o !== '0) begin n_err++; $display("FAIL period_tied: got %0d want 0", period_o); end
`endif
    endtask

    task automatic test_reset_mid_dead();
        int w;
        hall = hall_of[(cur_sector + 1) % 6];
        expect_comm(20, w);
        repeat (3) tick();
        rst = 1'b1; enable = 1'b0;
        tick();
        n_vec++; if (hi_o !== 3'b000 || lo_o !== 3'b000) begin n_err++; $display("FAIL rst_dead_gates: got %b/%b want 000/000", hi_o, lo_o); end
        n_vec++; if (sector_o !== 3'd7) begin n_err++; $display("FAIL rst_dead_sector: got %0d want 7", sector_o); end
        n_vec++; if (comm_o !== 1'b0 || fault_o !== 1'b0) begin n_err++; $display("FAIL rst_dead_flags: got comm %b fault %b want 0/0", comm_o, fault_o); end
        n_vec++; if (period_o !== '0) begin n_err++; $display("FAIL rst_dead_period: got %0d want 0", period_o); end
        rst = 1'b0;
        repeat (3) tick();
        n_vec++; if (sector_o !== 3'd7 || fault_o !== 1'b0) begin n_err++; $display("FAIL rst_dead_idle: got sector %0d fault %b want 7/0", sector_o, fault_o); end
        n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); end
    endtask

    initial begin
        hall_of = '{3'b001, 3'b101, 3'b100, 3'b110, 3'b010, 3'b011};
        hi_leg  = '{0, 0, 1, 1, 2, 2};
        lo_leg  = '{1, 2, 2, 0, 0, 1};
        test_reset();
        test_start();
        test_rotation(1'b0, "fwd");
        test_dir_toggle();
        test_rotation(1'b1, "rev");
        test_glitch();
        test_fault();
        test_pwm();
        test_speed();
        test_reset_mid_dead();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bldc_commutator.md
# bldc_commutator

Parametrised six-step BLDC commutation controller for the three-phase inverter gate stage. Samples the three Hall sensors, synchronises and debounces them, maps the Hall code to one of six sectors and drives the six gate outputs: high sides A/B/C and low sides Ad/Bd/Cd. It adds what the earlier combinational Hall decoder lacked: direction control, dead-time insertion on commutation, PWM chopping of the high side, and latched invalid-Hall fault detection.

## Interface
- DEBOUNCE, default 4: consecutive stable cycles required before a new Hall code is accepted (1..255).
- DEADTIME, default 8: cycles of dead time on each commutation (1..255).
- PWM_W, default 8: PWM counter and duty width.
- PER_W, default 20: commutation period counter width (BLDC_SPEED_EN only).
- clk  in  1  system clock; everything sits in this single clock domain.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  run request; low forces all gates off.
- dir  in  1  0 = forward, 1 = reverse.
- hall  in  3  asynchronous Hall inputs: hall[0]=H_1, hall[1]=H_2, hall[2]=H_3.
- duty  in  PWM_W  high-side on-count per PWM period.
- fault_clr  in  1  single-cycle pulse that clears a latched fault.
- hi  out  3  high-side gates {C,B,A}.
- lo  out  3  low-side gates {Cd,Bd,Ad}.
- sector  out  3  current sector 0..5; 7 when no valid sector.
- comm  out  1  one-cycle pulse on each accepted sector change.
- fault  out  1  latched invalid-Hall fault.
- period  out  PER_W  cycles between the last two commutations.

## Operation
- Hall path: 2-flop synchroniser, then debounce. The filtered code updates only after the synchronised code has been identical for DEBOUNCE consecutive cycles.
- Sector map (code = {H_3,H_2,H_1}): 001→0, 101→1, 100→2, 110→3, 010→4, 011→5. Codes 000 and 111 are invalid.
- Forward pattern, as high+/low−: s0 A+B−, s1 A+C−, s2 B+C−, s3 B+A−, s4 C+A−, s5 C+B−.
- Reverse pattern: same legs, with high and low swapped (s0 B+A−, etc.).
- PWM: a free-running PWM_W counter; pwm_on = (cnt < duty). Drive rule: hi = pattern_hi & pwm_on; lo = pattern_lo, never chopped. duty=0 keeps the high side off.
- States:
  - IDLE: gates off, sector=7. With enable=1 and a valid filtered code, go to DEAD.
  - DEAD: outputs = old_pattern & new_pattern, with the PWM gating applied to hi. Switches turning off drop at once; switches turning on wait. After DEADTIME cycles, go to RUN.
  - RUN: outputs = new pattern. A filtered-code change or a dir change loads a new pattern and goes to DEAD.
  - FAULT: gates off, fault=1. Exit to IDLE needs fault_clr=1 while the filtered code is valid.
- A code change while in DEAD restarts DEAD. The target becomes the newest pattern; old_pattern stays the pre-DEAD pattern.
- Fault entry: an invalid filtered code in any state except FAULT. This takes priority over everything except rst and enable=0.
- enable=0 forces IDLE from DEAD or RUN; FAULT stays latched.
- A hi/lo pair on the same leg is never 1 together in any state.

## Timing
- Reset values: hi=0, lo=0, sector=7, comm=0, fault=0, period=0, state=IDLE. The PWM counter, debounce counters and synchroniser are all cleared.
- Hall-edge latency: 2 (sync) + DEBOUNCE cycles to the filtered-code update. sector and comm update in the following cycle, at the same time as entry to DEAD.
- New gates turn on DEADTIME cycles after comm.
- All outputs are registered.
- rst mid-DEAD or mid-FAULT returns to IDLE with all outputs at their reset values on the next edge.

## Configuration
- BLDC_SPEED_EN defined:
  - PER_W counter increments every cycle and saturates at all-ones.
  - On each comm, the counter value is copied to period and the counter restarts at 1.
  - In IDLE or FAULT, the counter holds at 0.
- BLDC_SPEED_EN undefined: period is tied to 0 and no counter logic exists.

## Structure
- bldc_pkg holds:
  - state enum (IDLE, DEAD, RUN, FAULT)
  - hall→sector function
  - forward commutation table constant (6×{hi,lo})
  - SECTOR_NONE = 3'd7
- Sub-module bldc_hall_filter: synchroniser plus debounce, parametrised by DEBOUNCE, outputs the filtered 3-bit code.

## Test plan
- Forward rotation: DEBOUNCE=4, DEADTIME=8, duty=255, dir=0. Hall sequence 001,101,100,110,010,011, 100 cycles each → sector steps 0..5. Each step gives one comm pulse, and hi/lo match the table after 8 dead cycles. During s0→s1, lo[A] stays 0 and hi[A] stays on.
- Reverse: dir=1 with the same sequence → mirrored patterns. Toggling dir in RUN gives DEAD for 8 cycles with no shoot-through on any leg.
- Glitch rejection: a 3-cycle pulse on H_2 → no sector change, no comm. A 6-cycle stable change is accepted.
- Fault: hall=111 held for 6 cycles → FAULT; hi=lo=0, fault=1, sector=7. fault_clr while the code is 111 → still FAULT. Then code 001 + fault_clr → IDLE, then DEAD, then RUN at s0.
- PWM: duty=64, PWM_W=8 → hi on for 64 of every 256 cycles in RUN; lo constant. duty=0 → hi always 0.
- BLDC_SPEED_EN: Hall steps every 1000 cycles → period=1000 after the second comm. Reset mid-DEAD → all outputs at reset values in the next cycle.
